// File: rtl/conv_encoder_214.sv
// Rate-1/2, K=4 convolutional encoder with 3-bit zero tail per frame and a single output register.
// Define CONV_ENC_STATE_OUT_EN to expose the post-symbol trellis state on out_state.
module conv_encoder_214 #(
    parameter logic [3:0] G0 = 4'b1111,
    parameter logic [3:0] G1 = 4'b1101
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_bit,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_sym,
`ifdef CONV_ENC_STATE_OUT_EN
    output logic [2:0] out_state,
`endif
    output logic       out_last
);

    typedef enum logic [1:0] {StIdle, StData, StTail} state_e;

    state_e     state_q, state_d;
    logic [2:0] sr_q, sr_d;
    logic [1:0] tcnt_q, tcnt_d;
    logic       out_valid_q, out_valid_d;
    logic [1:0] out_sym_q, out_sym_d;
    logic       out_last_q, out_last_d;
    logic [2:0] out_state_q, out_state_d;

    logic       slot_free;
    logic       in_xfer;
    logic       tail_load;
    logic       u;
    logic [3:0] vec;
    logic [2:0] sr_next;
    logic [1:0] sym;

    assign slot_free = !out_valid_q || out_ready;
    assign in_ready  = rst_n && slot_free && (state_q != StTail);
    assign in_xfer   = in_valid && in_ready;
    assign tail_load = (state_q == StTail) && slot_free;

    // Tail slots always shift in a zero to drive the trellis back to state 000.
    assign u       = tail_load ? 1'b0 : in_bit;
    assign vec     = {u, sr_q};
    assign sym     = {^(vec & G0), ^(vec & G1)};
    assign sr_next = {u, sr_q[2:1]};

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        tcnt_d      = tcnt_q;
        out_valid_d = out_valid_q;
        out_sym_d   = out_sym_q;
        out_last_d  = out_last_q;
        out_state_d = out_state_q;

        if (in_xfer || tail_load) begin
            sr_d        = sr_next;
            out_sym_d   = sym;
            out_state_d = sr_next;
            out_valid_d = 1'b1;
            out_last_d  = 1'b0;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        case (state_q)
            StIdle, StData: begin
                if (in_xfer) begin
                    state_d = in_last ? StTail : StData;
                    tcnt_d  = 2'd0;
                end
            end
            StTail: begin
                if (tail_load) begin
                    if (tcnt_q == 2'd2) begin
                        state_d    = StIdle;
                        tcnt_d     = 2'd0;
                        out_last_d = 1'b1;
                    end else begin
                        tcnt_d = tcnt_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                tcnt_d  = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            sr_q        <= 3'b000;
            tcnt_q      <= 2'd0;
            out_valid_q <= 1'b0;
            out_sym_q   <= 2'b00;
            out_last_q  <= 1'b0;
            out_state_q <= 3'b000;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            tcnt_q      <= tcnt_d;
            out_valid_q <= out_valid_d;
            out_sym_q   <= out_sym_d;
            out_last_q  <= out_last_d;
            out_state_q <= out_state_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sym   = out_sym_q;
    assign out_last  = out_last_q;
`ifdef CONV_ENC_STATE_OUT_EN
    assign out_state = out_state_q;
`else
    logic unused_state;
    assign unused_state = ^out_state_q;
`endif

endmodule

// File: tb/tb_conv_encoder_214.sv
// Scoreboard bench for conv_encoder_214: a reference encoder model pushes expected symbols.
module tb_conv_encoder_214;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       in_bit;
    logic       in_last;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [1:0] out_sym;
    logic       out_last;
`ifdef CONV_ENC_STATE_OUT_EN
    logic [2:0] out_state;
`endif

    int n_vec = 0;
    int n_err = 0;
    int n_pop = 0;

    // Expected entry: {state_after[2:0], sym[1:0], last}
    logic [5:0] exp_q[$];
    logic [2:0] m_sr = 3'b000;

    logic       bp_mode = 1'b0;
    int         bp_cnt = 0;
    logic       stall_q = 1'b0;
    logic [2:0] held_q = 3'b000;

    conv_encoder_214 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sym   (out_sym),
`ifdef CONV_ENC_STATE_OUT_EN
        .out_state (out_state),
`endif
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] enc(input logic ub, input logic [2:0] s);
        return {ub ^ s[2] ^ s[1] ^ s[0], ub ^ s[2] ^ s[0]};
    endfunction

    task automatic push_sym(input logic ub, input logic last);
        logic [2:0] nxt;
        nxt = {ub, m_sr[2:1]};
        exp_q.push_back({nxt, enc(ub, m_sr), last});
        m_sr = nxt;
    endtask

    // Out_ready pattern 1,0,0,1 repeating when backpressure is on.
    always @(posedge clk) begin
        #1;
        if (bp_mode) begin
            out_ready = (bp_cnt % 4 == 0) || (bp_cnt % 4 == 3);
            bp_cnt++;
        end else begin
            out_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (stall_q)
                chk("stall_hold", {5'd0, out_valid, out_sym},
                    {5'd0, 1'b1, held_q[2:1]});
            stall_q = out_valid && !out_ready;
            held_q  = {out_sym, out_last};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $error("FAIL spurious_sym: observed sym %b last %b expected none",
                           out_sym, out_last);
                end else begin
                    logic [5:0] e;
                    e = exp_q.pop_front();
                    chk("sym_last", {5'd0, out_sym, out_last}, {5'd0, e[2:0]});
`ifdef CONV_ENC_STATE_OUT_EN
                    chk("out_state", {5'd0, out_state}, {5'd0, e[5:3]});
`endif
                end
                n_pop++;
            end
        end else begin
            stall_q = 1'b0;
        end
    end

    task automatic send_bit(input logic b, input logic l);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_bit   = b;
        in_last  = l;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $error("FAIL accept_timeout: observed in_ready 0 expected 1");
        end else begin
            push_sym(b, 1'b0);
            if (l) begin
                push_sym(1'b0, 1'b0);
                push_sym(1'b0, 1'b0);
                push_sym(1'b0, 1'b1);
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        chk("drain_empty", 8'(exp_q.size()), 8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] f1011;
        int base;
        f1011    = 4'b1011;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        in_last  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
        chk("rst_out_sym", {6'd0, out_sym}, 8'd0);
        chk("rst_out_last", {7'd0, out_last}, 8'd0);
        chk("rst_in_ready", {7'd0, in_ready}, 8'd0);
`ifdef CONV_ENC_STATE_OUT_EN
        chk("rst_out_state", {5'd0, out_state}, 8'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {7'd0, in_ready}, 8'd1);
        @(posedge clk);
        #1;

        // Impulse: in_ready must stay low for the three tail slots.
        send_bit(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("tail_in_ready", {7'd0, in_ready}, 8'd0);
        end
        @(negedge clk);
        chk("idle_in_ready", {7'd0, in_ready}, 8'd1);
        @(posedge clk);
        #1;
        drain();

        for (int i = 0; i < 8; i++) send_bit(1'b0, i == 7);
        drain();

        for (int i = 3; i >= 0; i--) send_bit(f1011[i], i == 0);
        drain();

        bp_mode = 1'b1;
        for (int i = 3; i >= 0; i--) send_bit(f1011[i], i == 0);
        drain();
        repeat (4) @(posedge clk);
        bp_mode = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back frames: in_valid never drops between them.
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        drain();

        // Reset in the middle of the impulse tail.
        base = n_pop;
        send_bit(1'b1, 1'b1);
        for (int i = 0; i < 50 && n_pop < base + 2; i++) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midreset_out_valid", {7'd0, out_valid}, 8'd0);
        chk("midreset_out_last", {7'd0, out_last}, 8'd0);
        chk("midreset_in_ready", {7'd0, in_ready}, 8'd0);
        exp_q.delete();
        m_sr = 3'b000;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_reset_out_valid", {7'd0, out_valid}, 8'd0);
        chk("after_reset_in_ready", {7'd0, in_ready}, 8'd1);
        @(posedge clk);
        #1;
        send_bit(1'b1, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
